// File: rtl/arith_pipe.sv
// Three-stage valid/ready pipeline computing ((a + b) - c) * d with a sticky per-result overflow flag.
// Define ARITH_PIPE_SAT_EN for saturating arithmetic; the default build wraps modulo 2^WIDTH.
module arith_pipe #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_ovf
);

  logic             v1_q, v2_q, v3_q;
  logic             o1_q, o2_q, o3_q;
  logic [WIDTH-1:0] s1_q, c1_q, d1_q;
  logic [WIDTH-1:0] s2_q, d2_q;
  logic [WIDTH-1:0] f3_q;

  logic               adv1, adv2, adv3;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               ovf1, unf2, ovf3;
  logic [WIDTH-1:0]   s1_d, s2_d, f3_d;

  // Each stage moves when it is empty or its successor moves, so bubbles collapse.
  always_comb begin
    adv3     = !v3_q || out_ready;
    adv2     = !v2_q || adv3;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    ovf1 = sum[WIDTH];
    s1_d = sum[WIDTH-1:0];
    unf2 = c1_q > s1_q;
    s2_d = s1_q - c1_q;
    prod = {{WIDTH{1'b0}}, s2_q} * {{WIDTH{1'b0}}, d2_q};
    ovf3 = |prod[2*WIDTH-1:WIDTH];
    f3_d = prod[WIDTH-1:0];
`ifdef ARITH_PIPE_SAT_EN
    if (ovf1) s1_d = '1;
    if (unf2) s2_d = '0;
    if (ovf3) f3_d = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      o1_q <= 1'b0;
      o2_q <= 1'b0;
      o3_q <= 1'b0;
      s1_q <= '0;
      c1_q <= '0;
      d1_q <= '0;
      s2_q <= '0;
      d2_q <= '0;
      f3_q <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; only the valids matter.
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
          c1_q <= c;
          d1_q <= d;
          o1_q <= ovf1;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_q <= s2_d;
          d2_q <= d1_q;
          o2_q <= o1_q | unf2;
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          f3_q <= f3_d;
          o3_q <= o2_q | ovf3;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_f     = f3_q;
  assign out_ovf   = o3_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Scoreboard bench for arith_pipe: the driver queues model results on acceptance, a monitor checks
// results as the consumer takes them. Build with ARITH_PIPE_SAT_EN to check the saturating variant.
module tb_arith_pipe;

  localparam int unsigned W = 10;
  localparam longint MAXV = 1 << W;
`ifdef ARITH_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] f;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_f;
  logic         out_ovf;

  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_stall = -1;
  bit           rand_on = 1'b0;
  bit           hold_valid = 1'b0;
  logic [W-1:0] hold_f;
  logic         hold_ovf;

  arith_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_f    (out_f),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic straight from the stage rules.
  function automatic exp_t model(input longint ia, input longint ib, input longint ic,
                                 input longint id);
    exp_t   e;
    longint s1, s2, p, f;
    bit     ovf;
    s1  = ia + ib;
    ovf = s1 >= MAXV;
    if (ovf) s1 = SAT ? MAXV - 1 : s1 - MAXV;
    if (ic > s1) begin
      ovf = 1'b1;
      s2  = SAT ? 0 : s1 + MAXV - ic;
    end else begin
      s2 = s1 - ic;
    end
    p = s2 * id;
    f = p;
    if (p >= MAXV) begin
      ovf = 1'b1;
      f   = SAT ? MAXV - 1 : p % MAXV;
    end
    e.f   = f[W-1:0];
    e.ovf = ovf;
    e.acc = 0;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                      input logic [W-1:0] id);
    exp_t e;
    bit   acc;
    int   n = 0;
    a = ia; b = ib; c = ic; d = id;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      if (acc) begin
        e     = model(ia, ib, ic, id);
        e.acc = cyc;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && out_valid) begin
        chk("stall_stable_f", out_f, hold_f);
        chk("stall_stable_ovf", out_ovf, hold_ovf);
      end
      hold_valid = out_valid && !out_ready;
      hold_f     = out_f;
      hold_ovf   = out_ovf;
      if (!out_ready) last_stall = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_f", out_f, e.f);
          chk("out_ovf", out_ovf, e.ovf);
          if (e.acc > last_stall) chk("latency", cyc - e.acc, 2);
          else chk("latency_min", (cyc - e.acc) >= 2, 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_f", out_f, 0);
    chk("reset_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back basic vectors and overflow/underflow corners.
    send(10, 12, 6, 3);
    send(10, 10, 5, 3);
    send(20, 11, 1, 4);
    send(1000, 100, 0, 1);
    send(10, 10, 30, 1);
    send(500, 0, 0, 3);
    send(1023, 1023, 0, 1023);
    send(0, 0, 0, 0);
    drain();

    // Stall: three fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'(i + 1), W'(2 * i), W'(i), W'(i + 2));
    @(negedge clk);
    chk("stall_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    fork
      begin
        send(7, 8, 9, 10);
        send(100, 200, 50, 2);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with three results in flight and a fresh operand set presented.
    out_ready = 1'b0;
    send(1, 2, 3, 4);
    send(5, 6, 7, 8);
    send(9, 10, 11, 12);
    a = 40; b = 40; c = 0; d = 1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_out_valid", out_valid, 0);
    send(30, 1, 2, 4);
    drain();

    // Asynchronous reset between edges with results in flight.
    send(3, 4, 1, 2);
    send(6, 6, 2, 2);
    send(8, 1, 1, 5);
    chk("pre_reset_out_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_out_f", out_f, 0);
    chk("async_reset_out_ovf", out_ovf, 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    send(12, 3, 5, 6);
    drain();

    // Randomized traffic with random consumer backpressure.
    rand_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      if ($urandom_range(0, 1) != 0) begin
        ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      end else begin
        ra = W'($urandom_range(0, 40)); rb = W'($urandom_range(0, 40));
        rc = W'($urandom_range(0, 60)); rd = W'($urandom_range(0, 20));
      end
      send(ra, rb, rc, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_on = 1'b0;
    @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
